// File: rtl/pwm_demod_if.sv
// Byte-stream output bundle of the GOC PWM demodulator.
//   out_data        : last completed byte
//   out_data_valid  : one-cycle strobe, out_data valid
//   out_frame_valid : high from first detected bit until idle timeout
//   out_frame_error : one-cycle strobe at frame end if the frame was malformed
// master = demodulator (drives), slave = frame writer / loopback checker.
interface pwm_demod_if;
  logic [7:0] out_data;
  logic       out_data_valid;
  logic       out_frame_valid;
  logic       out_frame_error;

  modport master (
    output out_data,
    output out_data_valid,
    output out_frame_valid,
    output out_frame_error
  );

  modport slave (
    input out_data,
    input out_data_valid,
    input out_frame_valid,
    input out_frame_error
  );
endinterface

// File: rtl/pwm_demod.sv
// GOC receive-side PWM demodulator.
// Measures high-pulse widths of the synchronised pad input against the slot
// length base_counter and recovers bits MSB-first into bytes. A bit cell is
// three slots: '1' = high 2 / low 1, '0' = high 1 / low 2. A low period of
// four slots closes the frame.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   GOC_IN        : raw asynchronous pad input
//   goc_polarity  : 1 = pad is inverted
//   base_counter  : slot length in clk cycles, 0 disables the block
//   bus           : byte / frame strobe outputs (pwm_demod_if.master)
// Optional: define GOC_RX_GLITCH_FILTER_EN for a 3-sample stable filter on
// the recovered line (2 clk extra latency, pulses <= 2 clk suppressed).
module pwm_demod #(
  parameter int unsigned CNT_W = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        GOC_IN,
  input  logic        goc_polarity,
  input  logic [21:0] base_counter,
  pwm_demod_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Input synchroniser and line recovery
  logic sync1_q, sync2_q;
  logic rx_raw;
  logic rx;
  logic rx_prev_q;
  logic rise, fall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= GOC_IN;
      sync2_q <= sync1_q;
    end
  end

  assign rx_raw = sync2_q ^ goc_polarity;

`ifdef GOC_RX_GLITCH_FILTER_EN
  // The line only follows rx_raw once three consecutive samples agree;
  // otherwise it holds its previous value (rx_prev_q).
  logic [1:0] hist_q;
  logic       agree;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= {hist_q[0], rx_raw};
    end
  end

  assign agree = (rx_raw == hist_q[0]) && (rx_raw == hist_q[1]);
  assign rx    = agree ? rx_raw : rx_prev_q;
`else
  assign rx = rx_raw;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_prev_q <= 1'b0;
    end else begin
      rx_prev_q <= rx;
    end
  end

  assign rise = rx & ~rx_prev_q;
  assign fall = ~rx & rx_prev_q;

  // Decision thresholds derived from the slot length
  logic [CNT_W-1:0] base_ext;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] long_thr;
  logic [CNT_W-1:0] tmo;
  logic             base_zero;

  assign base_ext  = CNT_W'(base_counter);
  assign thr       = base_ext + (base_ext >> 1);
  assign long_thr  = (base_ext << 1) + (base_ext >> 1);
  assign tmo       = base_ext << 2;
  assign base_zero = (base_counter == 22'd0);

  // Decoder state
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       sr_q;
  logic             err_q;
  logic             byte_pend_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             out_frame_q;
  logic             out_err_q;
  logic             bit_val;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign bit_val = (cnt_q >= thr);

  // Pulse-width FSM with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 3'd0;
      sr_q        <= 8'd0;
      err_q       <= 1'b0;
      byte_pend_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_frame_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      if (base_zero) begin
        // Disabled: drop any frame in progress without strobes
        state_q     <= IDLE;
        cnt_q       <= '0;
        bit_cnt_q   <= 3'd0;
        err_q       <= 1'b0;
        byte_pend_q <= 1'b0;
        out_data_q  <= 8'd0;
        out_frame_q <= 1'b0;
      end else begin
        // The shift register already holds the full byte one cycle after
        // the eighth falling edge.
        if (byte_pend_q) begin
          out_data_q  <= sr_q;
          out_valid_q <= 1'b1;
          byte_pend_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (rise) begin
              state_q     <= HIGH;
              cnt_q       <= CNT_W'(1);
              bit_cnt_q   <= 3'd0;
              err_q       <= 1'b0;
              out_frame_q <= 1'b1;
            end
          end
          HIGH: begin
            cnt_q <= cnt_inc;
            if (fall) begin
              if (cnt_q > long_thr) begin
                err_q <= 1'b1;
              end
              sr_q      <= {sr_q[6:0], bit_val};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_pend_q <= 1'b1;
              end
              state_q <= LOW;
              cnt_q   <= CNT_W'(1);
            end
          end
          LOW: begin
            cnt_q <= cnt_inc;
            if (rise) begin
              state_q <= HIGH;
              cnt_q   <= CNT_W'(1);
            end else if (cnt_q >= tmo) begin
              // >= rather than == so a mid-frame slot change cannot skip it
              out_frame_q <= 1'b0;
              out_err_q   <= (bit_cnt_q != 3'd0) || err_q;
              state_q     <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.out_data        = out_data_q;
  assign bus.out_data_valid  = out_valid_q;
  assign bus.out_frame_valid = out_frame_q;
  assign bus.out_frame_error = out_err_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Scoreboard bench for pwm_demod: expected bytes (with their due cycle) are
// queued as the pad waveform is driven and popped when out_data_valid fires.
module tb_pwm_demod;

`ifdef GOC_RX_GLITCH_FILTER_EN
  localparam int unsigned FLT       = 2;
  localparam int unsigned GLITCH_EF = 0;
`else
  localparam int unsigned FLT       = 0;
  localparam int unsigned GLITCH_EF = 1;
`endif
  localparam int unsigned BASE = 10;

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        GOC_IN;
  logic        goc_polarity;
  logic [21:0] base_counter;
  logic        inv = 1'b0;

  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  int unsigned fv_fall_cyc = 0;
  int unsigned fv_falls = 0;
  int unsigned err_seen = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        fv_prev = 1'b0;
  exp_t        sb_q[$];

  pwm_demod_if bus_if ();

  pwm_demod #(.CNT_W(24)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .GOC_IN       (GOC_IN),
    .goc_polarity (goc_polarity),
    .base_counter (base_counter),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (bus_if.out_data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 32'(bus_if.out_data), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("out_data", 32'(bus_if.out_data), 32'(e.data));
        check("valid_latency", cyc, e.due);
      end
    end
    if (bus_if.out_frame_error === 1'b1) err_seen++;
    if (fv_prev && bus_if.out_frame_valid !== 1'b1) begin
      fv_falls++;
      fv_fall_cyc = cyc;
    end
    fv_prev = (bus_if.out_frame_valid === 1'b1);
  end

  // Hold pad level v for n cycles
  task automatic drive(input logic v, input int n);
    @(posedge clk);
    #1 GOC_IN = v ^ inv;
    repeat (n - 1) @(posedge clk);
  endtask

  // One bit cell; optionally push the completed byte when this fall ends it
  task automatic send_bit(input logic b, input int hi_ovr, input logic push, input logic [7:0] d);
    int hi;
    int lo;
    hi = b ? 2 * BASE : BASE;
    lo = b ? BASE : 2 * BASE;
    if (hi_ovr != 0) hi = hi_ovr;
    drive(1'b1, hi);
    @(posedge clk);
    #1 GOC_IN = inv;
    last_fall = cyc;
    if (push) sb_q.push_back('{data: d, due: cyc + 4 + FLT});
    repeat (lo - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int msb_hi);
    for (int i = 7; i >= 0; i--) begin
      send_bit(d[i], (i == 7) ? msb_hi : 0, (i == 0), d);
    end
  endtask

  task automatic idle();
    drive(1'b0, 100);
  endtask

  // Change polarity with the block disabled so the transition is not decoded
  task automatic set_pol(input logic p);
    @(posedge clk);
    #1 base_counter = 22'd0;
    inv = p;
    goc_polarity = p;
    GOC_IN = p;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("disabled_fv", 32'(bus_if.out_frame_valid), 32'd0);
    check("disabled_data", 32'(bus_if.out_data), 32'd0);
    @(posedge clk);
    #1 base_counter = 22'(BASE);
  endtask

  task automatic check_frame(input string tag, input int unsigned e0, input int unsigned exp_err);
    check({tag, "_pending"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_errors"}, err_seen - e0, exp_err);
    check({tag, "_fv_low"}, 32'(bus_if.out_frame_valid), 32'd0);
  endtask

  initial begin
    int unsigned e0;
    int unsigned f0;
    logic [4:0]  five;
    resetn       = 1'b0;
    GOC_IN       = 1'b0;
    goc_polarity = 1'b0;
    base_counter = 22'(BASE);
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus_if.out_data), 32'd0);
    check("rst_valid", 32'(bus_if.out_data_valid), 32'd0);
    check("rst_fv", 32'(bus_if.out_frame_valid), 32'd0);
    check("rst_err", 32'(bus_if.out_frame_error), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte 0xA5 with timeout timing
    e0 = err_seen; f0 = fv_falls;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'(8'hA5 >> i), 0, (i == 0), 8'hA5);
      if (i == 4) check("a5_fv_high", 32'(bus_if.out_frame_valid), 32'd1);
    end
    idle();
    check_frame("a5", e0, 0);
    check("a5_fv_falls", fv_falls - f0, 32'd1);
    check("a5_fv_timing", fv_fall_cyc - last_fall, 32'(4 * BASE + 3 + FLT));

    // 0x00 then 0xFF in one frame
    e0 = err_seen; f0 = fv_falls;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    idle();
    check_frame("b2b", e0, 0);
    check("b2b_fv_falls", fv_falls - f0, 32'd1);

    // Partial frame of 5 bits
    e0 = err_seen;
    five = 5'b10110;
    for (int i = 4; i >= 0; i--) send_bit(five[i], 0, 1'b0, 8'h00);
    idle();
    check_frame("part5", e0, 1);

    // Over-long high pulse inside 0x80
    e0 = err_seen;
    send_byte(8'h80, 3 * BASE);
    idle();
    check_frame("long", e0, 1);

    // Single-clock glitch
    e0 = err_seen; f0 = fv_falls;
    drive(1'b1, 1);
    idle();
    check_frame("glitch", e0, GLITCH_EF);
    check("glitch_fv_falls", fv_falls - f0, GLITCH_EF);

    // Block disabled mid-frame: silent drop
    e0 = err_seen;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b0, 8'h00);
    @(posedge clk);
    #1 base_counter = 22'd0;
    repeat (10) @(posedge clk);
    #1 base_counter = 22'(BASE);
    idle();
    check_frame("base0", e0, 0);

    // Inverted pad
    set_pol(1'b1);
    e0 = err_seen;
    send_byte(8'h3C, 0);
    idle();
    check_frame("pol1", e0, 0);
    check("pol1_fv_timing", fv_fall_cyc - last_fall, 32'(4 * BASE + 3 + FLT));
    set_pol(1'b0);

    // Reset after bit 4 of 0xFF, then 0x3C
    e0 = err_seen;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 1'b0, 8'h00);
    @(posedge clk);
    #1 resetn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mrst_valid", 32'(bus_if.out_data_valid), 32'd0);
      check("mrst_fv", 32'(bus_if.out_frame_valid), 32'd0);
      check("mrst_data", 32'(bus_if.out_data), 32'd0);
    end
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (5) @(posedge clk);
    send_byte(8'h3C, 0);
    idle();
    check_frame("mrst", e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
